regfile_wb: RTL and testbench
=============================

REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid  in  1  load result offered
- lsu_ready  out  1  load result accepted when valid&ready
- lsu_rd  in  5  load destination register
- lsu_data  in  32  load data
- issue_valid  in  1  decode issued instruction with destination
- issue_rd  in  5  destination being issued
- wen  out  1  regfile write enable
- regW_sel  out  5  regfile write address
- regW_i  out  32  regfile write data
- busy_o  out  32  per-register pending-write bits
- regA_sel, regB_sel  in  5 each  regfile read addresses (bypass only)
- regA_i, regB_i  in  32 each  regfile read data (bypass only)
- regA_o, regB_o  out  32 each  forwarded read data (bypass only)

Function
REQ-002 The write port (wen, regW_sel, regW_i) SHALL be registered: a result selected in cycle N SHALL appear on the write port in cycle N+1 for exactly one cycle.
REQ-003 ALU results SHALL have strict priority; alu_valid in cycle N SHALL always produce a write in N+1.
REQ-004 Load results SHALL pass through a 2-entry FIFO; lsu_ready SHALL equal FIFO not full.
REQ-005 The FIFO head SHALL be selected for writeback only in a cycle with alu_valid low; the FIFO is in-order.
REQ-006 An enqueue and dequeue in the same cycle SHALL both occur; occupancy unchanged; enqueue into a full FIFO SHALL not occur (lsu_ready low).
REQ-007 A selected result with rd == 0 SHALL be consumed but SHALL produce wen = 0.
REQ-008 issue_valid with issue_rd != 0 SHALL set busy_o[issue_rd] at the next edge; busy_o[0] SHALL be constant 0.
REQ-009 A write presented on the write port SHALL clear busy_o[regW_sel] at the end of that cycle.
REQ-010 Simultaneous set (issue) and clear (commit) of the same register SHALL leave the bit set.
REQ-011 With no source selected, wen SHALL be 0; regW_sel and regW_i SHALL hold their previous values.

Reset
REQ-012 Asserting rst_n low SHALL immediately force wen = 0, regW_sel = 0, regW_i = 0, busy_o = 0, FIFO empty (lsu_ready = 1), independent of clk.
REQ-013 Reset mid-operation SHALL discard all buffered load results and pending busy bits; no write SHALL follow reset release without new input.

Configuration
REQ-014 With WB_BYPASS_EN defined, regA_o/regB_o SHALL combinationally equal regW_i when wen = 1 and the respective sel equals regW_sel (nonzero), else regA_i/regB_i.
REQ-015 Without WB_BYPASS_EN, the regA/regB bypass ports SHALL be absent and no forwarding logic SHALL be built.

Structure
REQ-016 Package wb_pkg SHALL hold XLEN = 32, REG_ADDR_W = 5, WB_FIFO_DEPTH = 2 and typedef wb_entry_t {rd, data}.
REQ-017 The load buffer SHALL be a sub-module wb_fifo (parameterised on depth, element wb_entry_t, full/empty outputs).

Verification
REQ-018 Reset release, idle -> wen 0, busy_o 0, lsu_ready 1 for 10 cycles.
REQ-019 alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF in cycle N -> cycle N+1: wen 1, regW_sel 5, regW_i DEADBEEF; N+2: wen 0.
REQ-020 alu_valid held high 4 cycles while lsu offers rd=7/data=1, rd=8/data=2, rd=9/data=3 -> lsu_ready drops after two accepts; after ALU stops, writes to 7 then 8 on consecutive cycles, then 9 accepted and written.
REQ-021 issue rd=3, then ALU write rd=3 while issue rd=3 again same cycle -> busy_o[3] stays 1; issue rd=0 -> busy_o[0] stays 0; ALU write rd=0 -> wen 0.
REQ-022 WB_BYPASS_EN: write rd=4 data=32'h12345678 on port with regA_sel=4, regA_i=0 -> regA_o=12345678 same cycle; regB_sel=0 -> regB_o=regB_i.
REQ-023 rst_n pulsed low with FIFO holding 2 entries and busy_o nonzero -> outputs cleared asynchronously; no writes after release.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg -- shared types and sizes for the writeback arbiter.
//   XLEN          : datapath width
//   REG_ADDR_W    : register address width
//   NUM_REGS      : number of architectural registers (busy vector width)
//   WB_FIFO_DEPTH : depth of the load-result buffer
//   wb_entry_t    : one pending writeback {rd, data}
package wb_pkg;
    localparam int XLEN          = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int NUM_REGS      = 1 << REG_ADDR_W;
    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- small in-order buffer of wb_entry_t used for load results.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (empties buffer)
//   push, pushEntry   : enqueue request and payload (ignored when full)
//   pop               : dequeue request (ignored when empty)
//   headEntry         : oldest entry, valid when !empty
//   full, empty       : occupancy flags
// Push and pop in the same cycle both take effect.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t pushEntry,
    input  logic      pop,
    output wb_entry_t headEntry,
    output logic      full,
    output logic      empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t           storage [DEPTH];
    logic [PTR_W-1:0]    wrPtr;
    logic [PTR_W-1:0]    rdPtr;
    logic [CNT_W-1:0]    count;
    logic                doPush;
    logic                doPop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign headEntry = storage[rdPtr];

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            storage[wrPtr] <= pushEntry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= ptrInc(wrPtr);
            if (doPop)  rdPtr <= ptrInc(rdPtr);
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_wb.sv
// regfile_wb -- writeback arbiter between ALU and load unit, with a
// per-register busy scoreboard.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data   : ALU result, always accepted, top priority
//   lsu_valid/lsu_rd/lsu_data   : load result, accepted when lsu_ready
//   lsu_ready                   : load buffer not full
//   issue_valid/issue_rd        : destination being issued (sets busy bit)
//   wen/regW_sel/regW_i         : registered regfile write port
//   busy_o                      : pending-write bit per register (bit 0 tied 0)
//   regA_*/regB_*               : read-port forwarding, only when WB_BYPASS_EN
// Optional feature macro: WB_BYPASS_EN (adds forwarding of the write port
// onto the two read ports).
module regfile_wb
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  wen,
    output logic [REG_ADDR_W-1:0] regW_sel,
    output logic [XLEN-1:0]       regW_i,
    output logic [NUM_REGS-1:0]   busy_o
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_ADDR_W-1:0] regA_sel,
    input  logic [REG_ADDR_W-1:0] regB_sel,
    input  logic [XLEN-1:0]       regA_i,
    input  logic [XLEN-1:0]       regB_i,
    output logic [XLEN-1:0]       regA_o,
    output logic [XLEN-1:0]       regB_o
`endif
);
    wb_entry_t             lsuEntry;
    wb_entry_t             fifoHead;
    wb_entry_t             selEntry;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  lsuPush;
    logic                  lsuPop;
    logic                  selValid;

    logic                  wenReg;
    logic [REG_ADDR_W-1:0] regWSelReg;
    logic [XLEN-1:0]       regWDataReg;
    logic [NUM_REGS-1:0]   busyReg;
    logic [NUM_REGS-1:0]   setMask;
    logic [NUM_REGS-1:0]   clrMask;

    assign lsuEntry  = '{rd: lsu_rd, data: lsu_data};
    assign lsu_ready = !fifoFull;
    assign lsuPush   = lsu_valid && !fifoFull;
    // The buffer only drains in cycles the ALU leaves free.
    assign lsuPop    = !alu_valid && !fifoEmpty;

    wb_fifo #(.DEPTH(WB_FIFO_DEPTH)) loadBuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lsuPush),
        .pushEntry (lsuEntry),
        .pop       (lsuPop),
        .headEntry (fifoHead),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    always_comb begin
        selValid = 1'b0;
        selEntry = '0;
        if (alu_valid) begin
            selValid = 1'b1;
            selEntry = '{rd: alu_rd, data: alu_data};
        end else if (!fifoEmpty) begin
            selValid = 1'b1;
            selEntry = fifoHead;
        end
    end

    // A selected rd==0 result is consumed but never raises wen; address
    // and data hold whenever nothing is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wenReg      <= 1'b0;
            regWSelReg  <= '0;
            regWDataReg <= '0;
        end else begin
            wenReg <= selValid && (selEntry.rd != '0);
            if (selValid) begin
                regWSelReg  <= selEntry.rd;
                regWDataReg <= selEntry.data;
            end
        end
    end

    assign wen      = wenReg;
    assign regW_sel = regWSelReg;
    assign regW_i   = regWDataReg;

    // Register 0 never gets a set or clear, so its busy bit stays 0.
    assign setMask[0] = 1'b0;
    assign clrMask[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : genBusyMask
            assign setMask[gi] = issue_valid && (issue_rd == REG_ADDR_W'(gi));
            assign clrMask[gi] = wenReg && (regWSelReg == REG_ADDR_W'(gi));
        end
    endgenerate

    // Set wins over clear: a re-issue in the commit cycle stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyReg <= '0;
        end else begin
            busyReg <= (busyReg & ~clrMask) | setMask;
        end
    end

    assign busy_o = busyReg;

`ifdef WB_BYPASS_EN
    assign regA_o = (wenReg && (regA_sel != '0) && (regA_sel == regWSelReg)) ? regWDataReg : regA_i;
    assign regB_o = (wenReg && (regB_sel != '0) && (regB_sel == regWSelReg)) ? regWDataReg : regB_i;
`endif
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb -- self-checking bench for regfile_wb: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_regfile_wb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        wen;
    logic [4:0]  regW_sel;
    logic [31:0] regW_i;
    logic [31:0] busy_o;
`ifdef WB_BYPASS_EN
    logic [4:0]  regA_sel = '0;
    logic [4:0]  regB_sel = '0;
    logic [31:0] regA_i = '0;
    logic [31:0] regB_i = '0;
    logic [31:0] regA_o;
    logic [31:0] regB_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wen         (wen),
        .regW_sel    (regW_sel),
        .regW_i      (regW_i),
        .busy_o      (busy_o)
`ifdef WB_BYPASS_EN
        ,
        .regA_sel    (regA_sel),
        .regB_sel    (regB_sel),
        .regA_i      (regA_i),
        .regB_i      (regB_i),
        .regA_o      (regA_o),
        .regB_o      (regB_o)
`endif
    );

    // Reference model: load queue, current write-port contents, busy set.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } mEntry;

    mEntry       mq[$];
    bit          mWen;
    logic [4:0]  mSel;
    logic [31:0] mData;
    logic [31:0] mBusy;

    task automatic modelReset();
        mq.delete();
        mWen  = 1'b0;
        mSel  = '0;
        mData = '0;
        mBusy = '0;
    endtask

    task automatic setIn(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input bit iv, input logic [4:0] ird);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        issue_valid = iv; issue_rd = ird;
    endtask

    task automatic idle();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock; model follows: ALU first, else oldest load;
    // load accepted when fewer than 2 are buffered; commit clears, issue sets.
    task automatic tick();
        mEntry       sel;
        mEntry       inEntry;
        bit          haveSel;
        bit          accept;
        logic [31:0] nb;
        haveSel = 0;
        accept  = lsu_valid && (mq.size() < 2);
        inEntry.rd = lsu_rd;
        inEntry.data = lsu_data;
        if (alu_valid) begin
            haveSel = 1; sel.rd = alu_rd; sel.data = alu_data;
        end else if (mq.size() > 0) begin
            haveSel = 1; sel = mq.pop_front();
        end
        nb = mBusy;
        if (mWen) nb[mSel] = 1'b0;
        if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
        @(posedge clk);
        if (accept) mq.push_back(inEntry);
        mBusy = nb;
        mWen  = haveSel && (sel.rd != 0);
        if (haveSel) begin
            mSel = sel.rd; mData = sel.data;
        end
        #1;
    endtask

    task automatic test_reset();
        modelReset();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", wen); end
        checks++; if (regW_sel !== 5'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", regW_sel); end
        checks++; if (regW_i !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", regW_i); end
        checks++; if (busy_o !== 32'd0) begin errors++; $display("FAIL rst_busy got %h exp 0", busy_o); end
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", lsu_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (wen !== 1'b0 || busy_o !== 32'd0 || lsu_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_after_rst cyc %0d got wen %b busy %h ready %b exp 0 0 1", i, wen, busy_o, lsu_ready);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_alu_single();
        setIn(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tick();
        idle();
        checks++;
        if (wen !== 1'b1 || regW_sel !== 5'd5 || regW_i !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_write got %b/%0d/%h exp 1/5/deadbeef", wen, regW_sel, regW_i);
        end
        tick();
        checks++;
        if (wen !== 1'b0 || regW_sel !== 5'd5 || regW_i !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_hold got %b/%0d/%h exp 0/5/deadbeef", wen, regW_sel, regW_i);
        end
        $display("test_alu_single done");
    endtask

    task automatic test_lsu_fifo();
        logic [4:0]  aluRd[4]   = '{5'd10, 5'd11, 5'd12, 5'd13};
        logic [4:0]  lsuRd[4]   = '{5'd7, 5'd8, 5'd9, 5'd9};
        logic [31:0] lsuDat[4]  = '{32'd1, 32'd2, 32'd3, 32'd3};
        bit          expRdy[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            setIn(1, aluRd[c], 32'hA000_0000 + c, 1, lsuRd[c], lsuDat[c], 0, 0);
            checks++;
            if (lsu_ready !== expRdy[c]) begin
                errors++; $display("FAIL fifo_ready cyc %0d got %b exp %b", c, lsu_ready, expRdy[c]);
            end
            tick();
            checks++;
            if (wen !== 1'b1 || regW_sel !== aluRd[c]) begin
                errors++; $display("FAIL fifo_alu cyc %0d got %b/%0d exp 1/%0d", c, wen, regW_sel, aluRd[c]);
            end
        end
        setIn(0, 0, 0, 1, 9, 3, 0, 0);
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL fifo_full got %b exp 0", lsu_ready); end
        tick();
        checks++;
        if (wen !== 1'b1 || regW_sel !== 5'd7 || regW_i !== 32'd1) begin
            errors++; $display("FAIL fifo_wr7 got %b/%0d/%h exp 1/7/1", wen, regW_sel, regW_i);
        end
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL fifo_reopen got %b exp 1", lsu_ready); end
        tick();
        lsu_valid = 1'b0;
        checks++;
        if (wen !== 1'b1 || regW_sel !== 5'd8 || regW_i !== 32'd2) begin
            errors++; $display("FAIL fifo_wr8 got %b/%0d/%h exp 1/8/2", wen, regW_sel, regW_i);
        end
        tick();
        checks++;
        if (wen !== 1'b1 || regW_sel !== 5'd9 || regW_i !== 32'd3) begin
            errors++; $display("FAIL fifo_wr9 got %b/%0d/%h exp 1/9/3", wen, regW_sel, regW_i);
        end
        tick();
        checks++;
        if (wen !== 1'b0 || lsu_ready !== 1'b1) begin
            errors++; $display("FAIL fifo_drained got wen %b ready %b exp 0 1", wen, lsu_ready);
        end
        $display("test_lsu_fifo done");
    endtask

    task automatic test_busy();
        setIn(0, 0, 0, 0, 0, 0, 1, 3);
        tick();
        checks++; if (busy_o[3] !== 1'b1) begin errors++; $display("FAIL busy_set got %b exp 1", busy_o[3]); end
        setIn(1, 3, 32'h33, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (wen !== 1'b1 || regW_sel !== 5'd3) begin
            errors++; $display("FAIL busy_commit got %b/%0d exp 1/3", wen, regW_sel);
        end
        setIn(0, 0, 0, 0, 0, 0, 1, 3);
        tick();
        checks++; if (busy_o[3] !== 1'b1) begin errors++; $display("FAIL busy_set_wins got %b exp 1", busy_o[3]); end
        setIn(0, 0, 0, 0, 0, 0, 1, 6);
        tick();
        setIn(1, 6, 32'h66, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        checks++;
        if (busy_o[6] !== 1'b0 || busy_o[3] !== 1'b1) begin
            errors++; $display("FAIL busy_clear got b6 %b b3 %b exp 0 1", busy_o[6], busy_o[3]);
        end
        setIn(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL busy_r0 got %b exp 0", busy_o[0]); end
        setIn(1, 0, 32'hFF, 0, 0, 0, 0, 0);
        tick();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL wen_r0 got %b exp 0", wen); end
        setIn(1, 3, 32'h3, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        checks++; if (busy_o !== 32'd0) begin errors++; $display("FAIL busy_all_clear got %h exp 0", busy_o); end
        $display("test_busy done");
    endtask

    task automatic test_reset_mid();
        setIn(1, 1, 32'h11, 1, 20, 32'h20, 1, 22);
        tick();
        setIn(1, 2, 32'h22, 1, 21, 32'h21, 1, 23);
        tick();
        idle();
        checks++;
        if (lsu_ready !== 1'b0 || busy_o === 32'd0) begin
            errors++; $display("FAIL mid_setup got ready %b busy %h exp 0 nonzero", lsu_ready, busy_o);
        end
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checks++;
        if (wen !== 1'b0 || regW_sel !== 5'd0 || regW_i !== 32'd0 || busy_o !== 32'd0 || lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_rst got %b/%0d/%h/%h/%b exp 0/0/0/0/1", wen, regW_sel, regW_i, busy_o, lsu_ready);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (wen !== 1'b0 || busy_o !== 32'd0) begin
                errors++; $display("FAIL post_rst cyc %0d got wen %b busy %h exp 0 0", i, wen, busy_o);
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            setIn($urandom_range(0, 2) == 0, 5'($urandom), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom));
            checks++;
            if (lsu_ready !== (mq.size() < 2)) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, lsu_ready, mq.size() < 2);
            end
            tick();
            checks++;
            if (wen !== mWen || (mWen && (regW_sel !== mSel || regW_i !== mData))) begin
                errors++;
                $display("FAIL rnd_write cyc %0d got %b/%0d/%h exp %b/%0d/%h", i, wen, regW_sel, regW_i, mWen, mSel, mData);
            end
            checks++;
            if (busy_o !== mBusy) begin
                errors++; $display("FAIL rnd_busy cyc %0d got %h exp %h", i, busy_o, mBusy);
            end
        end
        idle();
        $display("test_random done");
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        setIn(1, 4, 32'h12345678, 0, 0, 0, 0, 0);
        tick();
        idle();
        regA_sel = 5'd4; regA_i = 32'd0;
        regB_sel = 5'd0; regB_i = 32'hCAFEF00D;
        #1;
        checks++;
        if (regA_o !== 32'h12345678) begin errors++; $display("FAIL byp_a got %h exp 12345678", regA_o); end
        checks++;
        if (regB_o !== 32'hCAFEF00D) begin errors++; $display("FAIL byp_b got %h exp cafef00d", regB_o); end
        tick();
        checks++;
        if (regA_o !== 32'd0) begin errors++; $display("FAIL byp_a_idle got %h exp 0", regA_o); end
        $display("test_bypass done");
    endtask
`endif

    initial begin
        idle();
        #12;
        test_reset();
        test_alu_single();
        test_lsu_fifo();
        test_busy();
        test_reset_mid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
